uart_boot_loader: RTL and testbench

Parametrised UART program loader and memory dumper sitting between the chip-level UART pins and the CPU instruction/data memory. After reset it holds the CPU, receives a fixed-size image over 8N1 UART, packs bytes into words and writes them to memory. It then releases the CPU. On request it dumps the same memory region back over UART, with the CPU held again. It generalises the current fixed-width bootloader in word width, image depth, baud divisor and read-back mode.

---
 rtl/uart_boot_loader.sv | 168 ++++++++++++++++
 tb/tb_uart_boot_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: loads a DEPTH-word image over 8N1 UART into memory, then releases the CPU and dumps memory on request.
// Ports: clk, rst_n (async active-low), ce (global clock enable)
//        rx / tx          UART pins, idle high
//        scan_memory      dump request level, honoured only while the CPU runs
//        mem_addr, mem_wdata, mem_we, mem_re, mem_rdata   word memory port, read data one cycle after mem_re
//        cpu_hold         CPU reset while loading or dumping
//        frame_err        sticky low-stop-bit flag
module uart_boot_loader #(
  parameter int CLKS_PER_BIT = 104,
  parameter int WORD_BYTES   = 4,
  parameter int ADDR_W       = 8,
  parameter int DEPTH        = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ce,
  input  logic                    scan_memory,
  input  logic                    rx,
  output logic                    tx,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [8*WORD_BYTES-1:0] mem_wdata,
  output logic                    mem_we,
  output logic                    mem_re,
  input  logic [8*WORD_BYTES-1:0] mem_rdata,
  output logic                    cpu_hold,
  output logic                    frame_err
);
  localparam int DW = 8*WORD_BYTES;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT/2-1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT-1);
  typedef enum logic [2:0] {LOAD, WRITE, RUN, DUMP_RD, DUMP_LAT, DUMP_TX, DUMP_END} state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_t;
  state_t state, state_n;
  rx_t rx_st;
  logic [1:0] sync;
  logic rx_prev, rx_valid, tx_busy, tx_go, last;
  logic [CW-1:0] rx_cnt, tx_cnt;
  logic [2:0] rx_bit;
  logic [3:0] tx_bit, cnt, cnt_n;
  logic [7:0] rx_sh;
  logic [9:0] tx_sh;
  logic [ADDR_W-1:0] addr_n;
  logic [DW-1:0] wdata_n, dword, dword_n;
  // Receiver: edge-triggered start, start bit re-checked at mid-bit so a short glitch falls back to idle.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= 2'b11;
      rx_prev <= 1'b1;
      rx_st <= RX_IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
    end else if (ce) begin
      sync <= {sync[0], rx};
      rx_prev <= sync[1];
      rx_valid <= 1'b0;
      rx_cnt <= rx_cnt + 1'b1;
      case (rx_st)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (rx_prev && !sync[1]) rx_st <= RX_START;
        end
        RX_START: if (rx_cnt == HALF) begin
          rx_cnt <= '0;
          rx_bit <= '0;
          rx_st <= sync[1] ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (rx_cnt == LAST) begin
          rx_cnt <= '0;
          rx_sh <= {sync[1], rx_sh[7:1]};
          rx_bit <= rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_st <= RX_STOP;
        end
        RX_STOP: if (rx_cnt == LAST) begin
          rx_st <= RX_IDLE;
          rx_valid <= sync[1];
          frame_err <= frame_err | !sync[1];
        end
      endcase
    end
  // Transmitter: frame shifts out LSB first and refills with ones, so an idle shifter drives the line high.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_sh <= '1;
      tx_busy <= 1'b0;
      tx_cnt <= '0;
      tx_bit <= '0;
    end else if (ce) begin
      if (tx_go) begin
        tx_sh <= {1'b1, dword[7:0], 1'b0};
        tx_busy <= 1'b1;
        tx_cnt <= '0;
        tx_bit <= '0;
      end else if (tx_busy) begin
        tx_cnt <= tx_cnt + 1'b1;
        if (tx_cnt == LAST) begin
          tx_cnt <= '0;
          tx_sh <= {1'b1, tx_sh[9:1]};
          tx_bit <= tx_bit + 4'd1;
          if (tx_bit == 4'd9) tx_busy <= 1'b0;
        end
      end
    end
  assign tx = tx_sh[0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= LOAD;
      mem_addr <= '0;
      mem_wdata <= '0;
      cnt <= '0;
      dword <= '0;
    end else if (ce) begin
      state <= state_n;
      mem_addr <= addr_n;
      mem_wdata <= wdata_n;
      cnt <= cnt_n;
      dword <= dword_n;
    end
  assign last = mem_addr == ADDR_W'(DEPTH-1);
  // cnt is the byte lane while loading and the bytes-sent count while dumping.
  always_comb begin
    state_n = state;
    addr_n = mem_addr;
    wdata_n = mem_wdata;
    cnt_n = cnt;
    dword_n = dword;
    tx_go = 1'b0;
    case (state)
      LOAD: if (rx_valid) begin
        for (int i = 0; i < WORD_BYTES; i++)
          if (cnt == 4'(i)) wdata_n[8*i +: 8] = rx_sh;
        cnt_n = cnt + 4'd1;
        if (cnt + 4'd1 == 4'(WORD_BYTES)) state_n = WRITE;
      end
      WRITE: begin
        cnt_n = '0;
        state_n = last ? RUN : LOAD;
        addr_n = last ? '0 : mem_addr + 1'b1;
      end
      RUN: if (scan_memory) state_n = DUMP_RD;
      DUMP_RD: state_n = DUMP_LAT;
      DUMP_LAT: begin
        dword_n = mem_rdata;
        cnt_n = '0;
        state_n = DUMP_TX;
      end
      DUMP_TX: if (!tx_busy) begin
        if (cnt != 4'(WORD_BYTES)) begin
          tx_go = 1'b1;
          dword_n = dword >> 8;
          cnt_n = cnt + 4'd1;
        end else begin
          cnt_n = '0;
          state_n = last ? DUMP_END : DUMP_RD;
          addr_n = last ? '0 : mem_addr + 1'b1;
        end
      end
      DUMP_END: if (!scan_memory) state_n = RUN;
      default: state_n = LOAD;
    endcase
  end
  assign mem_we = state == WRITE;
  assign mem_re = state == DUMP_RD;
  assign cpu_hold = state != RUN;
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: directed self-checking bench for uart_boot_loader (4 clocks/bit, 4-byte words, 4 words).
module tb_uart_boot_loader;
  localparam int CPB = 4, WB = 4, AW = 8, DEPTH = 4;
  logic clk = 0, rst_n = 0, ce = 1, scan_memory = 0, rx = 1;
  logic tx, mem_we, mem_re, cpu_hold, frame_err;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata = '0;
  logic [31:0] mem [DEPTH];
  int pass = 0, total = 0, cyc = 0;
  logic [31:0] wr_data_q[$];
  logic [AW-1:0] wr_addr_q[$];
  int wr_cyc_q[$];
  logic [7:0] tx_q[$];
  int tx_cyc_q[$];
  int tx_bad_stop = 0, hold_fall_cyc = -1, hold_drop = 0;
  logic hold_prev = 1'b1;
  bit dumping = 0;
  int st[16];
  logic [31:0] exp_w[4] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};

  always #5 clk = ~clk;

  uart_boot_loader #(.CLKS_PER_BIT(CPB), .WORD_BYTES(WB), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .scan_memory(scan_memory), .rx(rx), .tx(tx),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .cpu_hold(cpu_hold), .frame_err(frame_err)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) mem[mem_addr[1:0]] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr[1:0]];
  end

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
      wr_cyc_q.push_back(cyc);
    end
    if (hold_prev === 1'b1 && cpu_hold === 1'b0) hold_fall_cyc = cyc;
    hold_prev = cpu_hold;
    if (dumping && cpu_hold !== 1'b1) hold_drop++;
  end

  // counts only clock edges on which the DUT was enabled
  task automatic wait_en(input int n);
    int i = 0;
    while (i < n) begin
      @(posedge clk);
      if (ce) i++;
    end
  endtask

  // UART line decoder for tx, timed in enabled cycles so ce stalls stretch it like the DUT
  initial begin
    logic [7:0] b;
    int t0;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        t0 = cyc;
        wait_en(CPB/2);
        @(negedge clk);
        for (int j = 0; j < 8; j++) begin
          wait_en(CPB);
          @(negedge clk);
          b[j] = tx;
        end
        wait_en(CPB);
        @(negedge clk);
        if (tx !== 1'b1) tx_bad_stop++;
        tx_q.push_back(b);
        tx_cyc_q.push_back(t0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop, output int t);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    @(negedge clk);
    t = cyc;
    for (int j = 0; j < 10; j++) begin
      if (j > 0) @(negedge clk);
      rx = f[j];
      wait_en(CPB);
    end
    @(negedge clk);
    rx = 1'b1;
    wait_en(3);
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(negedge clk);
    total++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else pass++;
    total++; if (mem_we !== 1'b0) $display("FAIL reset_we: got %b want 0", mem_we); else pass++;
    total++; if (mem_re !== 1'b0) $display("FAIL reset_re: got %b want 0", mem_re); else pass++;
    total++; if (mem_addr !== 8'h00) $display("FAIL reset_addr: got %h want 00", mem_addr); else pass++;
    total++; if (mem_wdata !== 32'h0) $display("FAIL reset_wdata: got %h want 0", mem_wdata); else pass++;
    total++; if (cpu_hold !== 1'b1) $display("FAIL reset_hold: got %b want 1", cpu_hold); else pass++;
    total++; if (frame_err !== 1'b0) $display("FAIL reset_ferr: got %b want 0", frame_err); else pass++;
    rst_n = 1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_load;
    int t;
    for (int b = 1; b <= 6; b++) send_byte(8'(b), 1'b1, t);
    repeat (10) @(negedge clk);
    total++; if (wr_addr_q.size() != 1) $display("FAIL midload_writes: got %0d want 1", wr_addr_q.size()); else pass++;
    total++; if (wr_data_q[0] !== 32'h04030201) $display("FAIL midload_word0: got %h want 04030201", wr_data_q[0]); else pass++;
    total++; if (mem_addr !== 8'h01) $display("FAIL midload_addr: got %h want 01", mem_addr); else pass++;
    total++; if (mem_wdata !== 32'h04030605) $display("FAIL midload_lanes: got %h want 04030605", mem_wdata); else pass++;
    rst_n = 0;
    #1;
    total++; if (mem_addr !== 8'h00) $display("FAIL rst_mid_addr: got %h want 00", mem_addr); else pass++;
    total++; if (mem_wdata !== 32'h0) $display("FAIL rst_mid_wdata: got %h want 0", mem_wdata); else pass++;
    total++; if (cpu_hold !== 1'b1 || mem_we !== 1'b0 || tx !== 1'b1) $display("FAIL rst_mid_ctrl: got hold=%b we=%b tx=%b want 1 0 1", cpu_hold, mem_we, tx); else pass++;
    repeat (2) @(negedge clk);
    rst_n = 1;
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_frame_err;
    send_byte(8'h01, 1'b1, st[0]);
    send_byte(8'h02, 1'b1, st[1]);
    send_byte(8'hAA, 1'b0, st[2]);
    repeat (10) @(negedge clk);
    total++; if (frame_err !== 1'b1) $display("FAIL ferr_flag: got %b want 1", frame_err); else pass++;
    total++; if (mem_wdata !== 32'h00000201) $display("FAIL ferr_lane: got %h want 00000201", mem_wdata); else pass++;
  endtask

  task automatic test_glitch;
    @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (CPB*12) @(negedge clk);
    total++; if (mem_wdata !== 32'h00000201) $display("FAIL glitch_lane: got %h want 00000201", mem_wdata); else pass++;
    total++; if (wr_addr_q.size() != 0 || cpu_hold !== 1'b1) $display("FAIL glitch_state: got writes=%0d hold=%b want 0 1", wr_addr_q.size(), cpu_hold); else pass++;
  endtask

  task automatic test_basic_load;
    send_byte(8'h03, 1'b1, st[2]);
    repeat (4) @(negedge clk);
    total++; if (mem_wdata !== 32'h00030201) $display("FAIL ferr_refill: got %h want 00030201", mem_wdata); else pass++;
    for (int b = 4; b <= 16; b++) begin
      if (b == 8)
        fork
          send_byte(8'h08, 1'b1, st[7]);
          begin
            repeat (15) @(negedge clk);
            ce = 0;
            repeat (50) @(negedge clk);
            ce = 1;
          end
        join
      else
        send_byte(8'(b), 1'b1, st[b-1]);
    end
    repeat (20) @(negedge clk);
    total++; if (wr_addr_q.size() != 4) $display("FAIL load_count: got %0d want 4", wr_addr_q.size()); else pass++;
    for (int w = 0; w < 4; w++) begin
      total++; if (wr_addr_q[w] !== 8'(w) || wr_data_q[w] !== exp_w[w]) $display("FAIL load_word%0d: got %h@%0d want %h@%0d", w, wr_data_q[w], wr_addr_q[w], exp_w[w], w); else pass++;
    end
    total++; if (cpu_hold !== 1'b0) $display("FAIL load_release: got %b want 0", cpu_hold); else pass++;
    total++; if (hold_fall_cyc != wr_cyc_q[3] + 1) $display("FAIL load_hold_fall: got cycle %0d want %0d", hold_fall_cyc, wr_cyc_q[3] + 1); else pass++;
    total++; if (wr_cyc_q[1] - st[7] != wr_cyc_q[0] - st[3] + 50) $display("FAIL rx_ce_stall: got latency %0d want %0d", wr_cyc_q[1] - st[7], wr_cyc_q[0] - st[3] + 50); else pass++;
    total++; if (wr_cyc_q[2] - st[11] != wr_cyc_q[0] - st[3]) $display("FAIL rx_latency: got %0d want %0d", wr_cyc_q[2] - st[11], wr_cyc_q[0] - st[3]); else pass++;
  endtask

  task automatic test_dump;
    int n = 0, c0;
    tx_q.delete();
    tx_cyc_q.delete();
    @(negedge clk);
    scan_memory = 1;
    c0 = cyc;
    @(posedge clk);
    #1 dumping = 1;
    while (tx_q.size() < 16 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    total++; if (tx_q.size() != 16) $display("FAIL dump_count: got %0d want 16", tx_q.size()); else pass++;
    for (int i = 0; i < 16; i++) begin
      total++; if (tx_q[i] !== 8'(i + 1)) $display("FAIL dump_byte%0d: got %h want %h", i, tx_q[i], 8'(i + 1)); else pass++;
    end
    total++; if (tx_bad_stop != 0) $display("FAIL dump_stop: got %0d bad stop bits want 0", tx_bad_stop); else pass++;
    total++; if (tx_cyc_q[0] != c0 + 4) $display("FAIL dump_first_start: got cycle %0d want %0d", tx_cyc_q[0], c0 + 4); else pass++;
    total++; if (tx_cyc_q[1] - tx_cyc_q[0] != 41) $display("FAIL dump_byte_gap: got %0d want 41", tx_cyc_q[1] - tx_cyc_q[0]); else pass++;
    total++; if (tx_cyc_q[4] - tx_cyc_q[3] != 44) $display("FAIL dump_word_gap: got %0d want 44", tx_cyc_q[4] - tx_cyc_q[3]); else pass++;
    repeat (300) @(negedge clk);
    total++; if (tx_q.size() != 16 || cpu_hold !== 1'b1) $display("FAIL dump_no_repeat: got bytes=%0d hold=%b want 16 1", tx_q.size(), cpu_hold); else pass++;
    total++; if (hold_drop != 0) $display("FAIL dump_hold: got %0d released cycles want 0", hold_drop); else pass++;
    dumping = 0;
    scan_memory = 0;
    repeat (2) @(negedge clk);
    total++; if (cpu_hold !== 1'b0) $display("FAIL dump_release: got %b want 0", cpu_hold); else pass++;
  endtask

  task automatic test_ce_stall;
    int n = 0, bad = 0;
    tx_q.delete();
    tx_cyc_q.delete();
    @(negedge clk);
    scan_memory = 1;
    while (tx_q.size() < 5 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    ce = 0;
    repeat (50) @(negedge clk);
    ce = 1;
    n = 0;
    while (tx_q.size() < 16 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    total++; if (tx_q.size() != 16) $display("FAIL stall_count: got %0d want 16", tx_q.size()); else pass++;
    for (int i = 0; i < 16; i++) if (tx_q[i] !== 8'(i + 1)) bad++;
    total++; if (bad != 0 || tx_bad_stop != 0) $display("FAIL stall_bytes: got %0d wrong bytes %0d bad stops want 0 0", bad, tx_bad_stop); else pass++;
    total++; if (tx_cyc_q[6] - tx_cyc_q[5] != 91) $display("FAIL tx_ce_stall: got gap %0d want 91", tx_cyc_q[6] - tx_cyc_q[5]); else pass++;
    total++; if (tx_cyc_q[2] - tx_cyc_q[1] != 41) $display("FAIL stall_nominal_gap: got %0d want 41", tx_cyc_q[2] - tx_cyc_q[1]); else pass++;
    scan_memory = 0;
    repeat (3) @(negedge clk);
    total++; if (cpu_hold !== 1'b0) $display("FAIL stall_release: got %b want 0", cpu_hold); else pass++;
  endtask

  initial begin
    test_reset;
    test_reset_mid_load;
    test_frame_err;
    test_glitch;
    test_basic_load;
    test_dump;
    test_ce_stall;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
